xc20xx_cfg_loader: RTL and testbench

Serial configuration receiver for the XC20XX family, modelling the producer side of the CLB configuration parameters. It parses the serial bitstream (header, length count, framed data, stop bits) on DIN. Each complete frame is presented as a parallel word with an address on a valid/ready port, for the configuration-memory model that programs the CLB and interconnect cells. It also reports load completion and format errors.

---
 rtl/xc20xx_cfg_loader.sv | 132 +++++++++++++
 tb/tb_xc20xx_cfg_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/xc20xx_cfg_loader.sv
// rtl/xc20xx_cfg_loader.sv - XC20XX serial configuration receiver
// Parses the header, length count, pad and framed data on DIN and presents each frame on a valid/ready port.
module xc20xx_cfg_loader #(
  parameter int FRAME_BITS = 71,
  parameter int NUM_FRAMES = 46,
  parameter int STOP_BITS  = 3,
  parameter int ADDR_W     = 6
) (
  input  logic                  K,
  input  logic                  RESET_N,
  input  logic                  DIN,
  input  logic                  DIN_EN,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic [ADDR_W-1:0]     FRAME_ADDR,
  output logic                  FRAME_VALID,
  input  logic                  FRAME_READY,
  output logic [23:0]           LEN_COUNT,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam int CNT_MAX = (FRAME_BITS > 24) ? FRAME_BITS : 24;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]  LEN_LAST  = CNT_W'(23);
  localparam logic [CNT_W-1:0]  PAD_LAST  = CNT_W'(3);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_FRAMES - 1);

  typedef enum logic [3:0] {
    S_HUNT, S_LEN, S_PAD, S_START, S_DATA, S_STOP, S_WAIT_ACC, S_DONE, S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [4:0]            r_win;
  logic [4:0]            w_win_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] r_fdata;
  logic [ADDR_W-1:0]     r_faddr;
  logic [ADDR_W-1:0]     r_fcnt;
  logic [23:0]           r_len;
  logic                  r_valid;
  logic                  w_acc;
  logic                  w_slot_busy;
  logic                  w_load;

  assign w_win_nxt   = {r_win[3:0], DIN};
  assign FRAME_DATA  = r_fdata;
  assign FRAME_ADDR  = r_faddr;
  assign FRAME_VALID = r_valid;
  assign LEN_COUNT   = r_len;

  always_ff @(posedge K or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_HUNT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_WAIT_ACC) begin
      if (w_acc) w_state_nxt = S_DONE;
    end else if (DIN_EN) begin
      case (r_state)
        S_HUNT:  if (w_win_nxt == 5'b10010) w_state_nxt = S_LEN;
        S_LEN:   if (r_cnt == LEN_LAST) w_state_nxt = S_PAD;
        S_PAD: begin
          if (!DIN)                   w_state_nxt = S_ERR;
          else if (r_cnt == PAD_LAST) w_state_nxt = S_START;
        end
        S_START: w_state_nxt = DIN ? S_ERR : S_DATA;
        S_DATA:  if (r_cnt == DATA_LAST) w_state_nxt = S_STOP;
        S_STOP: begin
          if (!DIN)                        w_state_nxt = S_ERR;
          else if (r_cnt == STOP_LAST) begin
            if (w_slot_busy)               w_state_nxt = S_ERR;
            else if (r_fcnt == LAST_ADDR)  w_state_nxt = S_WAIT_ACC;
            else                           w_state_nxt = S_START;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_acc       = r_valid & FRAME_READY;
    w_slot_busy = r_valid & ~FRAME_READY;
    w_load      = DIN_EN & DIN & (r_state == S_STOP) & (r_cnt == STOP_LAST) & ~w_slot_busy;
    DONE        = (r_state == S_DONE);
    ERROR       = (r_state == S_ERR);
  end

  // Bit counter restarts on every state change so each field counts from zero.
  always_ff @(posedge K or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt   <= '0;
      r_win   <= '0;
      r_len   <= '0;
      r_shift <= '0;
    end else if (DIN_EN) begin
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state inside {S_LEN, S_PAD, S_DATA, S_STOP})
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_HUNT) r_win   <= w_win_nxt;
      if (r_state == S_LEN)  r_len   <= {r_len[22:0], DIN};
      if (r_state == S_DATA) r_shift <= {r_shift[FRAME_BITS-2:0], DIN};
    end
  end

  // Output slot: an error drops any presented frame for good.
  always_ff @(posedge K or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid <= 1'b0;
      r_fdata <= '0;
      r_faddr <= '0;
      r_fcnt  <= '0;
    end else begin
      if (w_state_nxt == S_ERR) r_valid <= 1'b0;
      else if (w_load)          r_valid <= 1'b1;
      else if (w_acc)           r_valid <= 1'b0;
      if (w_load) begin
        r_fdata <= r_shift;
        r_faddr <= r_fcnt;
        r_fcnt  <= r_fcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// tb/tb_xc20xx_cfg_loader.sv - directed bench for xc20xx_cfg_loader
module tb_xc20xx_cfg_loader;

  logic       K;
  logic       RESET_N;
  logic       DIN;
  logic       DIN_EN;
  logic [7:0] FRAME_DATA;
  logic [0:0] FRAME_ADDR;
  logic       FRAME_VALID;
  logic       FRAME_READY;
  logic [23:0] LEN_COUNT;
  logic       DONE;
  logic       ERROR;

  int checks = 0;
  int errors = 0;

  logic [7:0] acc_data [0:31];
  logic [0:0] acc_addr [0:31];
  int         acc_n = 0;
  int         base;

  xc20xx_cfg_loader #(
    .FRAME_BITS(8), .NUM_FRAMES(2), .STOP_BITS(3), .ADDR_W(1)
  ) dut (
    .K(K), .RESET_N(RESET_N), .DIN(DIN), .DIN_EN(DIN_EN),
    .FRAME_DATA(FRAME_DATA), .FRAME_ADDR(FRAME_ADDR), .FRAME_VALID(FRAME_VALID),
    .FRAME_READY(FRAME_READY), .LEN_COUNT(LEN_COUNT), .DONE(DONE), .ERROR(ERROR)
  );

  initial K = 1'b0;
  always #5 K = ~K;

  // Records every frame that will be accepted on the coming rising edge.
  always @(negedge K) begin
    if (RESET_N && FRAME_VALID && FRAME_READY && acc_n < 32) begin
      acc_data[acc_n] = FRAME_DATA;
      acc_addr[acc_n] = FRAME_ADDR;
      acc_n = acc_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge K);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    DIN_EN  = 1'b0;
    DIN     = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      repeat (gap) begin
        DIN_EN = 1'b0;
        DIN    = 1'($urandom_range(0, 1));
        tick();
      end
      DIN    = v[i];
      DIN_EN = 1'b1;
      tick();
    end
    DIN_EN = 1'b0;
    DIN    = 1'b0;
  endtask

  task automatic send_prefix(input int gap);
    send_bits(32'hF2, 8, gap);
    send_bits(32'h00001A, 24, gap);
    send_bits(32'hF, 4, gap);
  endtask

  task automatic send_frame(input logic [7:0] d, input int gap);
    send_bits(32'h0, 1, gap);
    send_bits({24'h0, d}, 8, gap);
    send_bits(32'h7, 3, gap);
  endtask

  task automatic nominal_tail(input string tag, input int b);
    chk({tag, "_f1_valid"}, 32'(FRAME_VALID), 32'h1);
    chk({tag, "_f1_addr"},  32'(FRAME_ADDR),  32'h1);
    chk({tag, "_f1_data"},  32'(FRAME_DATA),  32'h3C);
    chk({tag, "_done_pre"}, 32'(DONE),        32'h0);
    tick();
    chk({tag, "_done"},     32'(DONE),        32'h1);
    chk({tag, "_valid_off"},32'(FRAME_VALID), 32'h0);
    chk({tag, "_error"},    32'(ERROR),       32'h0);
    chk({tag, "_len"},      32'(LEN_COUNT),   32'h1A);
    chk({tag, "_acc_cnt"},  32'(acc_n - b),   32'h2);
    chk({tag, "_acc0_d"},   32'(acc_data[b]),   32'hA5);
    chk({tag, "_acc0_a"},   32'(acc_addr[b]),   32'h0);
    chk({tag, "_acc1_d"},   32'(acc_data[b+1]), 32'h3C);
    chk({tag, "_acc1_a"},   32'(acc_addr[b+1]), 32'h1);
  endtask

  initial begin
    RESET_N     = 1'b0;
    DIN         = 1'b0;
    DIN_EN      = 1'b0;
    FRAME_READY = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(FRAME_VALID), 32'h0);
    chk("rst_data",  32'(FRAME_DATA),  32'h0);
    chk("rst_addr",  32'(FRAME_ADDR),  32'h0);
    chk("rst_len",   32'(LEN_COUNT),   32'h0);
    chk("rst_done",  32'(DONE),        32'h0);
    chk("rst_error", 32'(ERROR),       32'h0);

    // Nominal load
    FRAME_READY = 1'b1;
    base = acc_n;
    send_prefix(0);
    chk("nom_len_mid", 32'(LEN_COUNT), 32'h1A);
    send_frame(8'hA5, 0);
    chk("nom_f0_valid", 32'(FRAME_VALID), 32'h1);
    chk("nom_f0_data",  32'(FRAME_DATA),  32'hA5);
    send_frame(8'h3C, 0);
    nominal_tail("nom", base);

    // Backpressure: frame 0 held, then released, then frame 1
    do_reset();
    FRAME_READY = 1'b0;
    base = acc_n;
    send_prefix(0);
    send_frame(8'hA5, 0);
    repeat (10) begin
      tick();
      chk("bp_hold_valid", 32'(FRAME_VALID), 32'h1);
      chk("bp_hold_data",  32'(FRAME_DATA),  32'hA5);
      chk("bp_hold_addr",  32'(FRAME_ADDR),  32'h0);
    end
    FRAME_READY = 1'b1;
    tick();
    chk("bp_f0_cleared", 32'(FRAME_VALID), 32'h0);
    send_frame(8'h3C, 0);
    nominal_tail("bp", base);

    // Overflow: nobody accepts
    do_reset();
    FRAME_READY = 1'b0;
    send_prefix(0);
    send_frame(8'hA5, 0);
    chk("ovf_pre_error", 32'(ERROR), 32'h0);
    send_frame(8'h3C, 0);
    chk("ovf_error", 32'(ERROR),       32'h1);
    chk("ovf_valid", 32'(FRAME_VALID), 32'h0);
    chk("ovf_done",  32'(DONE),        32'h0);
    FRAME_READY = 1'b1;
    tick();
    chk("ovf_done_hold",  32'(DONE),  32'h0);
    chk("ovf_error_hold", 32'(ERROR), 32'h1);

    // Start bit 1
    do_reset();
    FRAME_READY = 1'b1;
    send_prefix(0);
    chk("start_pre_error", 32'(ERROR), 32'h0);
    send_bits(32'h1, 1, 0);
    chk("start_error", 32'(ERROR), 32'h1);

    // Second stop bit 0
    do_reset();
    send_prefix(0);
    send_bits(32'h0, 1, 0);
    send_bits(32'hA5, 8, 0);
    send_bits(32'h2, 2, 0);
    chk("stop_error", 32'(ERROR),       32'h1);
    chk("stop_valid", 32'(FRAME_VALID), 32'h0);

    // Pad bit 0
    do_reset();
    send_bits(32'hF2, 8, 0);
    send_bits(32'h00001A, 24, 0);
    send_bits(32'h2, 2, 0);
    chk("pad_error", 32'(ERROR), 32'h1);
    chk("pad_done",  32'(DONE),  32'h0);

    // Leading zeros never match the preamble
    do_reset();
    send_bits(32'h02, 8, 0);
    send_bits(32'h00001A, 24, 0);
    chk("hunt_len",   32'(LEN_COUNT), 32'h0);
    chk("hunt_error", 32'(ERROR),     32'h0);

    // DIN_EN gating with random DIN during the gaps
    do_reset();
    FRAME_READY = 1'b1;
    base = acc_n;
    send_prefix(3);
    send_frame(8'hA5, 3);
    send_frame(8'h3C, 3);
    nominal_tail("gap", base);

    // Reset mid-frame while frame 0 is presented
    do_reset();
    FRAME_READY = 1'b0;
    send_prefix(0);
    send_frame(8'hA5, 0);
    send_bits(32'h0, 1, 0);
    send_bits(32'hA, 4, 0);
    chk("mid_pre_valid", 32'(FRAME_VALID), 32'h1);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("mid_valid", 32'(FRAME_VALID), 32'h0);
    chk("mid_data",  32'(FRAME_DATA),  32'h0);
    chk("mid_len",   32'(LEN_COUNT),   32'h0);
    chk("mid_error", 32'(ERROR),       32'h0);
    chk("mid_done",  32'(DONE),        32'h0);
    do_reset();
    FRAME_READY = 1'b1;
    base = acc_n;
    send_prefix(0);
    send_frame(8'hA5, 0);
    send_frame(8'h3C, 0);
    nominal_tail("mid", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
